// File: rtl/move_collector_pkg.sv
// Shared chess move definitions for the move collector: field offsets, word geometry and collector states.
package move_collector_pkg;

  localparam int MOVE_W     = 19;
  localparam int SLOTS      = 8;
  localparam int WORD_W     = 160;
  localparam int SLOT_IDX_W = 3;

  localparam int INV     = 18;
  localparam int PROMO   = 17;
  localparam int PAWN    = 16;
  localparam int PAWN2   = 15;
  localparam int EP      = 14;
  localparam int CASTLE  = 13;
  localparam int CAP     = 12;
  localparam int FROM_HI = 11;
  localparam int FROM_LO = 6;
  localparam int TO_HI   = 5;
  localparam int TO_LO   = 0;

  localparam logic [MOVE_W-1:0] INVALID_MOVE = {1'b1, 18'd0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_READ,
    ST_CAPT,
    ST_EMIT,
    ST_FIN
  } collector_state_t;

endpackage

// File: rtl/move_slot_unpacker.sv
// Selects one 19-bit move slot from a FIFO word and flags whether it should be emitted.
// MOVE_COLLECTOR_CAPTURE_ONLY_EN restricts eligibility to capture moves.
module move_slot_unpacker
  import move_collector_pkg::*;
(
  input  logic [WORD_W-1:0]     word,
  input  logic [SLOT_IDX_W-1:0] slot_idx,
  output logic [MOVE_W-1:0]     move,
  output logic                  eligible
);

  always_comb begin
    move = word[slot_idx*MOVE_W +: MOVE_W];
`ifdef MOVE_COLLECTOR_CAPTURE_ONLY_EN
    eligible = ((move & INVALID_MOVE) == '0) && move[CAP];
`else
    eligible = ((move & INVALID_MOVE) == '0);
`endif
  end

endmodule

// File: rtl/move_collector.sv
// Drains the per-square move FIFOs after generation and streams valid moves out one per cycle.
// Build option MOVE_COLLECTOR_CAPTURE_ONLY_EN emits only capture moves.
module move_collector #(
  parameter int NSQ    = 64,
  parameter int WORD_W = 160,
  parameter int CNT_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NSQ-1:0]        sqDone,
  input  logic [NSQ-1:0]        sqEmpty,
  input  logic [NSQ*WORD_W-1:0] sqFifoOut,
  output logic [NSQ-1:0]        sqRden,
  output logic                  mvValid,
  input  logic                  mvReady,
  output logic [18:0]           mvData,
  output logic [CNT_W-1:0]      moveCount,
  output logic                  busy,
  output logic                  done
);
  import move_collector_pkg::*;

  localparam int PTR_W = $clog2(NSQ);

  collector_state_t        state, state_nxt;
  logic [PTR_W-1:0]        ptr;
  logic [SLOT_IDX_W-1:0]   slot;
  logic [SLOT_IDX_W-1:0]   unpack_idx;
  logic [WORD_W-1:0]       word_p0;
  logic [MOVE_W-1:0]       slot_move;
  logic                    slot_ok;
  logic                    emit_last;

  // While a move is presented, look one slot ahead so a transfer can reload immediately.
  assign unpack_idx = mvValid ? slot - 3'd1 : slot;
  assign emit_last  = (slot == '0) && (mvValid ? mvReady : !slot_ok);

  move_slot_unpacker u_unpacker (
    .word     (word_p0),
    .slot_idx (unpack_idx),
    .move     (slot_move),
    .eligible (slot_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_WAIT;
      ST_WAIT: if (&sqDone) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (&sqEmpty)          state_nxt = ST_FIN;
        else if (!sqEmpty[ptr]) state_nxt = ST_READ;
      end
      ST_READ: state_nxt = ST_CAPT;
      ST_CAPT: state_nxt = ST_EMIT;
      ST_EMIT: if (emit_last) state_nxt = ST_SCAN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sqRden = '0;
    if (state == ST_READ) sqRden[ptr] = 1'b1;
  end

  // FIFO is non-showahead: q becomes valid in CAPT, one cycle after the READ request.
  always_ff @(posedge clk) begin
    if (state == ST_CAPT) word_p0 <= sqFifoOut[ptr*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      slot      <= 3'd7;
      mvValid   <= 1'b0;
      mvData    <= '0;
      moveCount <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            moveCount <= '0;
            ptr       <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!(&sqEmpty) && sqEmpty[ptr])
            ptr <= (ptr == PTR_W'(NSQ-1)) ? '0 : ptr + 1'b1;
        end
        ST_CAPT: slot <= 3'd7;
        ST_EMIT: begin
          if (mvValid) begin
            if (mvReady) begin
              if (moveCount != '1) moveCount <= moveCount + 1'b1;
              if (slot == '0) begin
                mvValid <= 1'b0;
              end else begin
                slot    <= slot - 3'd1;
                mvValid <= slot_ok;
                if (slot_ok) mvData <= slot_move;
              end
            end
          end else if (slot_ok) begin
            mvValid <= 1'b1;
            mvData  <= slot_move;
          end else if (slot != '0) begin
            slot <= slot - 3'd1;
          end
        end
        ST_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_collector.sv
// Randomized scoreboard bench for move_collector with a queue-based FIFO and move-order model.
`timescale 1ns/1ps
module tb_move_collector;
  localparam int NSQ    = 64;
  localparam int WORD_W = 160;
  localparam int CNT_W  = 10;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [NSQ-1:0]        sqDone;
  logic [NSQ-1:0]        sqEmpty;
  logic [NSQ*WORD_W-1:0] sqFifoOut;
  logic [NSQ-1:0]        sqRden;
  logic                  mvValid;
  logic                  mvReady;
  logic [18:0]           mvData;
  logic [CNT_W-1:0]      moveCount;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] fifo [NSQ][$];
  logic [18:0]       exp_q[$];
  int                exp_rd[$];
  int                rd_q[$];
  int                exp_cnt = 0;
  int                ready_mode = 0;
  logic              hold_pending = 1'b0;
  logic [18:0]       hold_data;

  logic [18:0]       mv_a;
  logic [18:0]       mv_b;
  logic [WORD_W-1:0] w12;

  always #5 clk = ~clk;

  move_collector #(.NSQ(NSQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .sqDone(sqDone), .sqEmpty(sqEmpty),
    .sqFifoOut(sqFifoOut), .sqRden(sqRden), .mvValid(mvValid), .mvReady(mvReady),
    .mvData(mvData), .moveCount(moveCount), .busy(busy), .done(done)
  );

  // Non-showahead FIFOs: a read request at an edge presents the popped word after that edge.
  always @(posedge clk) begin
    for (int i = 0; i < NSQ; i++) begin
      if (reset) fifo[i].delete();
      else if (sqRden[i] && fifo[i].size() > 0)
        sqFifoOut[i*WORD_W +: WORD_W] <= fifo[i].pop_front();
      sqEmpty[i] <= (fifo[i].size() == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       mvReady = 1'b1;
      1:       mvReady = ($urandom_range(0, 3) != 0);
      default: mvReady = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      checks++;
      if (!$onehot0(sqRden)) begin
        errors++;
        $display("FAIL rden_onehot: sqRden=%h has more than one bit set", sqRden);
      end
      for (int i = 0; i < NSQ; i++) if (sqRden[i]) rd_q.push_back(i);
      if (hold_pending) begin
        checks++;
        if (!mvValid || mvData != hold_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%h, required valid=1 data=%h",
                   mvValid, mvData, hold_data);
        end
      end
      hold_pending = 1'b0;
      if (mvValid && mvReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL move_extra: got move %h, none expected", mvData);
        end else begin
          logic [18:0] e;
          e = exp_q.pop_front();
          if (mvData != e) begin
            errors++;
            $display("FAIL move_data: got %h, expected %h", mvData, e);
          end
        end
      end else if (mvValid) begin
        hold_pending = 1'b1;
        hold_data    = mvData;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_word(input int sq, input logic [WORD_W-1:0] w);
    logic [18:0] m;
    bit ok;
    exp_rd.push_back(sq);
    for (int s = 7; s >= 0; s--) begin
      m  = w[s*19 +: 19];
      ok = !m[18];
`ifdef MOVE_COLLECTOR_CAPTURE_ONLY_EN
      ok = ok && m[12];
`endif
      if (ok) begin
        exp_q.push_back(m);
        exp_cnt++;
      end
    end
  endtask

  task automatic build_expect();
    exp_cnt = 0;
    for (int sq = 0; sq < NSQ; sq++)
      for (int j = 0; j < fifo[sq].size(); j++) expect_word(sq, fifo[sq][j]);
  endtask

  task automatic rand_word(input bit all_valid_cap, output logic [WORD_W-1:0] w);
    logic [18:0] m;
    w = '0;
    w[159:152] = 8'($urandom);
    for (int s = 0; s < 8; s++) begin
      m = 19'($urandom);
      if (all_valid_cap) begin
        m[18] = 1'b0;
        m[12] = 1'b1;
      end else begin
        m[18] = ($urandom_range(0, 9) < 3);
      end
      w[s*19 +: 19] = m;
    end
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, expected 1", name, limit);
    end
  endtask

  task automatic finish_pass(input string name);
    int sat;
    step();
    sat = (exp_cnt > 1023) ? 1023 : exp_cnt;
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_count"}, moveCount, sat);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 1);
    check({name, "_nreads"}, rd_q.size(), exp_rd.size());
    for (int k = 0; k < exp_rd.size() && k < rd_q.size(); k++)
      check({name, "_read_sq"}, rd_q[k], exp_rd[k]);
    exp_q.delete();
    exp_rd.delete();
    rd_q.delete();
  endtask

  task automatic run_pass(input string name, input int limit);
    build_expect();
    pulse_start();
    wait_done(name, limit);
    finish_pass(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WORD_W-1:0] w;
    int n;
    reset  = 1'b1;
    start  = 1'b0;
    sqDone = '1;
    repeat (4) step();
    check("rst_valid", mvValid, 0);
    check("rst_data", mvData, 0);
    check("rst_count", moveCount, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rden", sqRden, 0);
    reset = 1'b0;
    step();

    // All FIFOs empty: short pass with no reads.
    build_expect();
    pulse_start();
    check("empty_busy", busy, 1);
    step();
    step();
    check("empty_done_early", done, 0);
    step();
    check("empty_done", done, 1);
    finish_pass("empty");

    // Square 12: one capture and one quiet move, the rest invalid.
    mv_a = {7'b0000001, 6'o14, 6'o15};
    mv_b = {7'b0000000, 6'o14, 6'o24};
    w12  = '0;
    for (int s = 0; s < 8; s++) w12[s*19 +: 19] = {1'b1, 18'd0};
    w12[7*19 +: 19] = mv_a;
    w12[3*19 +: 19] = mv_b;
    ready_mode = 0;
    fifo[12].push_back(w12);
    run_pass("sq12", 200);

    // Same word with the consumer stalled for five cycles.
    fifo[12].push_back(w12);
    build_expect();
    ready_mode = 2;
    pulse_start();
    n = 0;
    while (!mvValid && n < 200) begin step(); n++; end
    check("stall_valid_seen", mvValid, 1);
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", mvValid, 1);
      check("stall_data", mvData, mv_a);
      check("stall_count", moveCount, 0);
      step();
    end
    ready_mode = 0;
    wait_done("stall", 200);
    finish_pass("stall");

    // Squares 0 and 63, plus a late word at square 5 that forces the scan pointer to wrap.
    rand_word(1'b0, w); fifo[0].push_back(w);
    rand_word(1'b0, w); fifo[63].push_back(w);
    rand_word(1'b0, w); fifo[63].push_back(w);
    build_expect();
    pulse_start();
    n = 0;
    while (rd_q.size() < 2 && n < 400) begin step(); n++; end
    check("wrap_second_read", rd_q.size() >= 2, 1);
    rand_word(1'b0, w);
    fifo[5].push_back(w);
    expect_word(5, w);
    wait_done("wrap", 600);
    finish_pass("wrap");

    // One square still generating holds the collector in its wait phase.
    sqDone[5] = 1'b0;
    rand_word(1'b0, w); fifo[20].push_back(w);
    build_expect();
    pulse_start();
    for (int c = 0; c < 20; c++) begin
      check("wait_rden", sqRden, 0);
      step();
    end
    check("wait_no_reads", rd_q.size(), 0);
    check("wait_busy", busy, 1);
    sqDone = '1;
    wait_done("wait", 200);
    finish_pass("wait");

    // Random content with random back-pressure.
    ready_mode = 1;
    for (int p = 0; p < 5; p++) begin
      int nsq;
      nsq = $urandom_range(1, 10);
      for (int k = 0; k < nsq; k++) begin
        int sq;
        int nw;
        sq = $urandom_range(0, NSQ-1);
        nw = $urandom_range(1, 3);
        for (int j = 0; j < nw; j++) begin
          rand_word(1'b0, w);
          fifo[sq].push_back(w);
        end
      end
      run_pass("random", 3000);
    end

    // More moves than the counter can hold.
    ready_mode = 0;
    for (int k = 0; k < 140; k++) begin
      rand_word(1'b1, w);
      fifo[k % NSQ].push_back(w);
    end
    run_pass("saturate", 6000);

    // Reset in the middle of a move stream.
    ready_mode = 1;
    rand_word(1'b1, w); fifo[3].push_back(w);
    rand_word(1'b1, w); fifo[3].push_back(w);
    build_expect();
    pulse_start();
    n = 0;
    while (!(mvValid && moveCount >= 2) && n < 400) begin step(); n++; end
    check("midrst_valid_seen", mvValid, 1);
    reset = 1'b1;
    step();
    check("midrst_valid", mvValid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", moveCount, 0);
    check("midrst_done", done, 0);
    check("midrst_rden", sqRden, 0);
    reset = 1'b0;
    exp_q.delete();
    exp_rd.delete();
    rd_q.delete();
    step();
    step();

    // Recovery pass after the reset.
    rand_word(1'b0, w); fifo[40].push_back(w);
    run_pass("recover", 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
